rv32i_prog_loader: RTL and testbench
====================================

# rv32i_prog_loader

Program loader that writes the instruction memory the core fetches from. It accepts a byte stream from the host/bridge side, packs bytes little-endian into 32-bit words and writes them to consecutive word addresses starting at the reset PC. It holds the core in reset while loading and releases it once the image is complete.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of the first written word (core reset PC)
- DEPTH_WORDS, 4096, instruction memory capacity in words; the overflow limit
- CW, $clog2(DEPTH_WORDS)+1, width of word_count (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begin a new load
- finish  in  1  single-cycle pulse, end of byte stream
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  byte accepted when s_valid && s_ready at a rising edge
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  32  byte address of write, word aligned
- imem_wdata  out  32  write data
- core_reset_n  out  1  active-low reset to the core
- busy  out  1  high in LOAD or FLUSH
- error  out  1  sticky overflow flag, cleared by start or reset
- word_count  out  CW  words written in current load

## Operation
- States: HALT (reset state), LOAD, FLUSH, RUN, ERROR.
- HALT: core_reset_n=0, s_ready=0. start -> LOAD.
- LOAD: s_ready = (word_count < DEPTH_WORDS). Accepted byte k (byte_cnt 0..3) goes to lane k of the pack register: bits [8k+7:8k]. The 4th byte produces a write and clears byte_cnt. finish -> FLUSH.
- FLUSH: if byte_cnt != 0, write the partial word with the unfilled upper lanes zero; then -> RUN. If byte_cnt == 0, go directly to RUN with no write.
- RUN: core_reset_n=1, s_ready=0. start -> LOAD.
- Write address = BASE_ADDR + 4*word_count. word_count increments by 1 on each write.
- Overflow: s_valid while in LOAD and word_count == DEPTH_WORDS -> ERROR. Sets error=1 and performs no write. ERROR holds the core in reset; start -> LOAD.
- start in any state: clears word_count, byte_cnt, the pack register and error, then enters LOAD. A load in progress is abandoned; no partial word is written.
- start has priority over finish in the same cycle.
- finish with an accepted byte in the same cycle: the byte is accepted first, then FLUSH. If that byte completes a word, the full-word write occurs and FLUSH writes nothing more.
- finish in HALT, RUN or ERROR is ignored. Bytes are never accepted outside LOAD.
- Reset values: core_reset_n=0, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, error=0, word_count=0, state HALT.

## Timing
- imem_we, imem_addr and imem_wdata are registered. The 4th byte accepted at edge N gives imem_we=1 during cycle N+1, exactly one cycle wide.
- A partial-word write from FLUSH is asserted the cycle after entering FLUSH.
- core_reset_n rises the cycle after entering RUN, which is at least one cycle after the last imem_we deasserts.
- core_reset_n falls one cycle after start.
- Throughput: 1 byte/cycle. s_ready has no combinational path from s_valid.
- Asynchronous reset mid-load: all outputs return to reset values immediately; no further writes.

## Structure
- loader_state_e (HALT, LOAD, FLUSH, RUN, ERROR) goes into the shared rv32i package.
- Sub-module prog_loader_packer: byte lane insertion, byte_cnt, word-complete flag and zero padding. The FSM, address counter and outputs stay in the top.

## Test plan
- Bytes 13 00 00 00 93 00 10 00, then finish -> writes 0x0000_0013 @0x8000_0000 and 0x0010_0093 @0x8000_0004; word_count=2; core_reset_n=1 afterwards.
- 5 bytes (4 filler bytes, then AB), then finish -> second write 0x0000_00AB @0x8000_0004; word_count=2.
- DEPTH_WORDS=2, 9 bytes offered -> s_ready=0 after the 8th byte; error=1; no third write; core_reset_n stays 0.
- reset_n pulsed after 6 bytes -> all outputs at reset values; exactly one write seen; no write after reset.
- finish in the same cycle as the 4th byte -> exactly one write, no extra FLUSH write; start during LOAD -> word_count=0, next write @0x8000_0000.
- s_valid gaps and random stalls -> identical write sequence to the back-to-back case.

Source files
------------

// File: rtl/rv32i_prog_loader_pkg.sv
// Shared types and helpers for the rv32i program loader.
//   loader_state_e : loader FSM states
//   lane_insert    : place one byte into a given little-endian lane of a word
package rv32i_prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_ERROR
    } loader_state_e;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/rv32i_prog_loader_packer.sv
// Byte-to-word packer for the program loader.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : drop any partial word (new load or after a flush write)
//   take         : a byte is accepted this cycle
//   data         : the accepted byte
//   byte_cnt     : lanes already filled in the pack register (0..3)
//   word_done    : this cycle's byte completes a word
//   full_word    : pack register with this cycle's byte inserted
//   pad_word     : pack register as-is; unfilled upper lanes are zero
module prog_loader_packer
    import rv32i_prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [1:0]  byte_cnt,
    output logic        word_done,
    output logic [31:0] full_word,
    output logic [31:0] pad_word
);

    logic [31:0] pack;

    assign full_word = lane_insert(pack, byte_cnt, data);
    assign word_done = take && (byte_cnt == 2'd3);
    // Lanes are filled in order from a cleared register, so the upper
    // unfilled lanes are already zero.
    assign pad_word  = pack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (clear || word_done) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (take) begin
            pack     <= full_word;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/rv32i_prog_loader.sv
// Program loader: packs a host byte stream little-endian into 32-bit words
// and writes them to instruction memory from BASE_ADDR upward, holding the
// core in reset until the image is complete.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start, finish         : single-cycle load begin / stream end pulses
//   s_valid, s_data       : byte stream in; s_ready accepts
//   imem_we/addr/wdata    : registered one-cycle memory write
//   core_reset_n          : active-low core reset
//   busy, error           : loading / sticky overflow
//   word_count            : words written in the current load
module rv32i_prog_loader
    import rv32i_prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    localparam int         CW          = $clog2(DEPTH_WORDS) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          finish,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_reset_n,
    output logic          busy,
    output logic          error,
    output logic [CW-1:0] word_count
);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

    loader_state_e state;

    logic        full;
    logic        take;
    logic        pk_clear;
    logic [1:0]  byte_cnt;
    logic        word_done;
    logic [31:0] full_word;
    logic [31:0] pad_word;
    logic [31:0] wr_addr;

    assign full     = (word_count == DEPTH_CNT);
    // s_ready depends only on registered state, never on s_valid.
    assign s_ready  = (state == ST_LOAD) && !full;
    // start abandons the load, so a byte offered alongside it is not taken.
    assign take     = s_valid && s_ready && !start;
    assign pk_clear = start || (state == ST_FLUSH);
    assign busy     = (state == ST_LOAD) || (state == ST_FLUSH);
    assign wr_addr  = BASE_ADDR + (32'(word_count) << 2);

    prog_loader_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pk_clear),
        .take      (take),
        .data      (s_data),
        .byte_cnt  (byte_cnt),
        .word_done (word_done),
        .full_word (full_word),
        .pad_word  (pad_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HALT;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_reset_n <= 1'b0;
            error        <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state        <= ST_LOAD;
                word_count   <= '0;
                error        <= 1'b0;
                core_reset_n <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        core_reset_n <= 1'b0;
                        if (s_valid && full) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            if (word_done) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= wr_addr;
                                imem_wdata <= full_word;
                                word_count <= word_count + 1'b1;
                            end
                            // A byte taken with finish lands first; if it
                            // completed a word, byte_cnt is 0 in FLUSH.
                            if (finish) state <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (byte_cnt != 2'd0) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wr_addr;
                            imem_wdata <= pad_word;
                            word_count <= word_count + 1'b1;
                        end
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        // Wait out a flush write still on the bus.
                        core_reset_n <= !imem_we;
                    end
                    default: begin
                        core_reset_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_prog_loader.sv
// Scoreboard bench for rv32i_prog_loader: a full-depth instance (a_*) for
// the load flows and a DEPTH_WORDS=2 instance (b_*) for overflow.
module tb_rv32i_prog_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 0, a_finish = 0, a_valid = 0;
    logic [7:0]  a_data = 0;
    logic        a_ready, a_we, a_rst, a_busy, a_error;
    logic [31:0] a_addr, a_wdata;
    logic [12:0] a_count;

    logic        b_start = 0, b_finish = 0, b_valid = 0;
    logic [7:0]  b_data = 0;
    logic        b_ready, b_we, b_rst, b_busy, b_error;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_count;

    int total = 0;
    int bad = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];

    rv32i_prog_loader dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .finish(a_finish),
        .s_valid(a_valid), .s_data(a_data), .s_ready(a_ready),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_reset_n(a_rst), .busy(a_busy), .error(a_error),
        .word_count(a_count)
    );

    rv32i_prog_loader #(.DEPTH_WORDS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .finish(b_finish),
        .s_valid(b_valid), .s_data(b_data), .s_ready(b_ready),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_reset_n(b_rst), .busy(b_busy), .error(b_error),
        .word_count(b_count)
    );

    // Monitors: every write strobe pops one expected write.
    always @(negedge clk) begin : mon_a
        wr_t e;
        if (a_we === 1'b1) begin
            total++;
            if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL a_write unexpected: got addr=%h data=%h, want none", a_addr, a_wdata);
            end else begin
                e = exp_a.pop_front();
                if (a_addr !== e.addr || a_wdata !== e.data) begin
                    bad++;
                    $display("FAIL a_write: got addr=%h data=%h, want addr=%h data=%h",
                             a_addr, a_wdata, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t e;
        if (b_we === 1'b1) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL b_write unexpected: got addr=%h data=%h, want none", b_addr, b_wdata);
            end else begin
                e = exp_b.pop_front();
                if (b_addr !== e.addr || b_wdata !== e.data) begin
                    bad++;
                    $display("FAIL b_write: got addr=%h data=%h, want addr=%h data=%h",
                             b_addr, b_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_a.push_back(w);
    endtask

    task automatic push_b(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_b.push_back(w);
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic pulse_start_a();
        a_start = 1;
        @(negedge clk);
        a_start = 0;
    endtask

    task automatic pulse_finish_a();
        a_finish = 1;
        @(negedge clk);
        a_finish = 0;
    endtask

    task automatic send_a(input logic [7:0] b, input logic fin);
        int n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_ready=%b, want 1", a_ready);
        end
        a_valid = 1;
        a_data = b;
        a_finish = fin;
        @(negedge clk);
        a_valid = 0;
        a_finish = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] prog[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        reset_n = 1;
        @(negedge clk);

        // Reset state
        chk("rst_core_reset_n", 32'(a_rst), 32'd0);
        chk("rst_s_ready", 32'(a_ready), 32'd0);
        chk("rst_imem_we", 32'(a_we), 32'd0);
        chk("rst_imem_addr", a_addr, 32'd0);
        chk("rst_imem_wdata", a_wdata, 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_error", 32'(a_error), 32'd0);
        chk("rst_word_count", 32'(a_count), 32'd0);

        // Two full words, then finish
        pulse_start_a();
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_s_ready", 32'(a_ready), 32'd1);
        push_a(32'h8000_0000, 32'h0000_0013);
        push_a(32'h8000_0004, 32'h0010_0093);
        for (int i = 0; i < 8; i++) send_a(prog[i], 1'b0);
        pulse_finish_a();
        idle(5);
        chk("t1_word_count", 32'(a_count), 32'd2);
        chk("t1_core_reset_n", 32'(a_rst), 32'd1);
        chk("t1_busy_done", 32'(a_busy), 32'd0);
        chk("t1_pending", 32'(exp_a.size()), 32'd0);

        // Partial last word padded with zeros
        pulse_start_a();
        chk("t2_core_reset_n_low", 32'(a_rst), 32'd0);
        push_a(32'h8000_0000, 32'h4433_2211);
        push_a(32'h8000_0004, 32'h0000_00AB);
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b0);
        send_a(8'h44, 1'b0);
        send_a(8'hAB, 1'b0);
        pulse_finish_a();
        idle(5);
        chk("t2_word_count", 32'(a_count), 32'd2);
        chk("t2_core_reset_n", 32'(a_rst), 32'd1);
        chk("t2_pending", 32'(exp_a.size()), 32'd0);

        // Async reset mid-load
        pulse_start_a();
        push_a(32'h8000_0000, 32'h0403_0201);
        for (int i = 1; i <= 6; i++) send_a(8'(i), 1'b0);
        idle(1);
        reset_n = 0;
        #1;
        chk("t3_core_reset_n", 32'(a_rst), 32'd0);
        chk("t3_s_ready", 32'(a_ready), 32'd0);
        chk("t3_imem_we", 32'(a_we), 32'd0);
        chk("t3_imem_addr", a_addr, 32'd0);
        chk("t3_imem_wdata", a_wdata, 32'd0);
        chk("t3_busy", 32'(a_busy), 32'd0);
        chk("t3_word_count", 32'(a_count), 32'd0);
        @(negedge clk);
        reset_n = 1;
        idle(5);
        chk("t3_pending", 32'(exp_a.size()), 32'd0);
        chk("t3_core_reset_n_after", 32'(a_rst), 32'd0);

        // finish together with the 4th byte
        pulse_start_a();
        push_a(32'h8000_0000, 32'hDDCC_BBAA);
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b0);
        send_a(8'hCC, 1'b0);
        send_a(8'hDD, 1'b1);
        idle(5);
        chk("t4_word_count", 32'(a_count), 32'd1);
        chk("t4_core_reset_n", 32'(a_rst), 32'd1);
        chk("t4_pending", 32'(exp_a.size()), 32'd0);

        // start during LOAD abandons the partial word
        pulse_start_a();
        push_a(32'h8000_0000, 32'h5453_5251);
        for (int i = 0; i < 5; i++) send_a(8'h51 + 8'(i), 1'b0);
        chk("t5_word_count_pre", 32'(a_count), 32'd1);
        pulse_start_a();
        chk("t5_word_count_clr", 32'(a_count), 32'd0);
        push_a(32'h8000_0000, 32'h0000_00EE);
        send_a(8'hEE, 1'b0);
        pulse_finish_a();
        idle(5);
        chk("t5_word_count", 32'(a_count), 32'd1);
        chk("t5_pending", 32'(exp_a.size()), 32'd0);

        // Gaps and stalls give the same writes as back-to-back
        pulse_start_a();
        push_a(32'h8000_0000, 32'h0000_0013);
        push_a(32'h8000_0004, 32'h0010_0093);
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)));
            send_a(prog[i], 1'b0);
        end
        idle(2);
        pulse_finish_a();
        idle(5);
        chk("t6_word_count", 32'(a_count), 32'd2);
        chk("t6_core_reset_n", 32'(a_rst), 32'd1);
        chk("t6_pending", 32'(exp_a.size()), 32'd0);

        // Overflow on the two-word instance
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        push_b(32'h8000_0000, 32'h0403_0201);
        push_b(32'h8000_0004, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) begin
            b_valid = 1;
            b_data = 8'(i);
            @(negedge clk);
        end
        b_valid = 0;
        chk("ov_s_ready", 32'(b_ready), 32'd0);
        chk("ov_word_count", 32'(b_count), 32'd2);
        chk("ov_error_pre", 32'(b_error), 32'd0);
        b_valid = 1;
        b_data = 8'h09;
        @(negedge clk);
        b_valid = 0;
        chk("ov_error", 32'(b_error), 32'd1);
        chk("ov_core_reset_n", 32'(b_rst), 32'd0);
        b_finish = 1;
        @(negedge clk);
        b_finish = 0;
        idle(4);
        chk("ov_error_sticky", 32'(b_error), 32'd1);
        chk("ov_core_reset_n_hold", 32'(b_rst), 32'd0);
        chk("ov_word_count_hold", 32'(b_count), 32'd2);
        chk("ov_pending", 32'(exp_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
